// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: default datapath width and reset PC, fetch FSM encoding, canonical NOP word.
package fetch_pkg;

    localparam int              XLEN         = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, inst} pairs; flush has priority over push and pop.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller must not push when full (such a push is dropped).
// Ports: push/push_dat write side; pop/pop_dat read side (pop_dat reads 0 while empty);
//        flush empties the buffer; full/empty/count report occupancy.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, rd_ptr_q;

    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign pop_dat = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage needs no reset: the head is masked to 0 while empty.
    always_ff @(posedge clk) begin
        if (push && !full && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: holds the PC, issues one imem read at a time, buffers {pc, inst} for decode.
// Latency: first request two cycles after reset release; a response at cycle t reaches decode at t+1.
// Backpressure: a request is issued only while the output buffer has room for its response.
// Ports: clk/rst_n (synchronous, active low); redirect_valid/redirect_pc from the PC-select mux;
//        imem_req_*/imem_resp_* memory side; inst_* decode side; pc_plus4/fetch_pc to the mux.
module pc_fetch_unit #(
    parameter int              XLEN       = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = fetch_pkg::RESET_PC_DEF,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] fetch_pc
);

    import fetch_pkg::*;

    localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] FOUR      = XLEN'(4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [XLEN-1:0] hold_addr_q, hold_addr_d;
    logic            hold_q, hold_d;             // request shown to memory, not yet accepted
    logic            hold_redir_q, hold_redir_d; // redirect seen while that request was held
    logic            drop_pending_q, drop_pending_d;

    logic            req_hs;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [2*XLEN-1:0] fifo_head;

    assign fetch_pc   = fetch_pc_q;
    assign pc_plus4   = fetch_pc_q + FOUR;
    assign inst_valid = !fifo_empty;
    assign fifo_pop   = inst_valid && inst_ready;
    assign {inst_pc, inst_data} = fifo_head;

    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        inflight_pc_d  = inflight_pc_q;
        hold_addr_d    = hold_addr_q;
        hold_d         = hold_q;
        hold_redir_d   = hold_redir_q;
        drop_pending_d = drop_pending_q;
        imem_req_valid = 1'b0;
        // A held request keeps its original address even if the PC is redirected meanwhile.
        imem_req_addr  = hold_q ? hold_addr_q : fetch_pc_q;
        req_hs         = 1'b0;
        fifo_push      = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                // Occupancy below depth reserves a slot for this request's response.
                imem_req_valid = hold_q || (fifo_count < DEPTH_C);
                req_hs         = imem_req_valid && imem_req_ready;
                if (req_hs) begin
                    state_d        = ST_WAIT;
                    inflight_pc_d  = imem_req_addr;
                    hold_d         = 1'b0;
                    hold_redir_d   = 1'b0;
                    // A redirected held request is stale: drop its data, keep the new PC.
                    drop_pending_d = hold_redir_q;
                    if (!hold_redir_q) begin
                        fetch_pc_d = fetch_pc_q + FOUR;
                    end
                end else if (imem_req_valid) begin
                    hold_d       = 1'b1;
                    hold_addr_d  = imem_req_addr;
                    hold_redir_d = hold_redir_q || redirect_valid;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    fifo_push      = !drop_pending_q && !redirect_valid;
                    drop_pending_d = 1'b0;
                    state_d        = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & WORD_MASK;
            if (req_hs || (state_q == ST_WAIT && !imem_resp_valid)) begin
                drop_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            fetch_pc_q     <= RESET_PC;
            inflight_pc_q  <= '0;
            hold_addr_q    <= '0;
            hold_q         <= 1'b0;
            hold_redir_q   <= 1'b0;
            drop_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fetch_pc_q     <= fetch_pc_d;
            inflight_pc_q  <= inflight_pc_d;
            hold_addr_q    <= hold_addr_d;
            hold_q         <= hold_d;
            hold_redir_q   <= hold_redir_d;
            drop_pending_q <= drop_pending_d;
        end
    end

    // The request credit guarantees a response always finds a free slot.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(fifo_push && fifo_full));
        end
    end

    fetch_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (fifo_push),
        .push_dat ({inflight_pc_q, imem_resp_data}),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

    localparam logic [31:0] K       = 32'hA5A5_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, redirect_valid, imem_req_ready, imem_resp_valid, inst_ready;
    logic [31:0] redirect_pc, imem_resp_data;
    logic        imem_req_valid, inst_valid;
    logic [31:0] imem_req_addr, inst_data, inst_pc, pc_plus4, fetch_pc;
    logic        w_imem_req_valid, w_inst_valid;
    logic [31:0] w_imem_req_addr, w_inst_data, w_inst_pc, w_pc_plus4, w_fetch_pc;

    pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
        .pc_plus4(pc_plus4), .fetch_pc(fetch_pc));

    // Same stimulus, different reset PC: control timing is identical, addresses wrap.
    pc_fetch_unit #(.XLEN(32), .RESET_PC(WRAP_PC), .FIFO_DEPTH(2)) u_wrap (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(w_imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(w_imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(w_inst_valid), .inst_ready(inst_ready), .inst_data(w_inst_data), .inst_pc(w_inst_pc),
        .pc_plus4(w_pc_plus4), .fetch_pc(w_fetch_pc));

    int compared = 0;
    int mismatched = 0;

    // Drive knobs applied at each step.
    bit          drv_rst_n, drv_req_ready, drv_inst_ready, drv_redirect, junk_en, rand_delay;
    logic [31:0] drv_redirect_pc;
    int          resp_delay = 1;

    // Reference model: memory with one outstanding read, expected decode queue, expected PC.
    logic [63:0] exp_q[$];
    bit          out_vld, out_killed, hold, hold_killed;
    logic [31:0] out_addr, hold_addr, exp_addr;
    int          out_cnt, since_rst, cyc;

    // Per-step observations of the DUT.
    bit          hs_this, pop_this;
    logic [31:0] hs_addr, pop_pc, pop_dat;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        out_vld = 0; out_killed = 0; hold = 0; hold_killed = 0;
        exp_addr = 32'h0; since_rst = 0;
    endtask

    task automatic step();
        bit          resp_now, exp_vld, hs;
        logic [31:0] ea;
        @(negedge clk);
        rst_n          = drv_rst_n;
        imem_req_ready = drv_req_ready;
        inst_ready     = drv_inst_ready;
        redirect_valid = drv_redirect;
        redirect_pc    = drv_redirect_pc;
        resp_now        = out_vld && (out_cnt == 0);
        imem_resp_valid = resp_now || (!out_vld && junk_en && ($urandom_range(3) == 0));
        imem_resp_data  = resp_now ? (out_addr ^ K) : $urandom;
        #1;
        hs_this  = imem_req_valid && drv_req_ready;
        hs_addr  = imem_req_addr;
        pop_this = inst_valid && drv_inst_ready;
        pop_pc   = inst_pc;
        pop_dat  = inst_data;
        if (!drv_rst_n) begin
            model_reset();
        end else begin
            ea      = hold ? hold_addr : exp_addr;
            exp_vld = (since_rst >= 1) && !out_vld && (hold || exp_q.size() < 2);
            check("req_valid", imem_req_valid, exp_vld);
            if (exp_vld) check("req_addr", imem_req_addr, ea);
            check("fetch_pc", fetch_pc, exp_addr);
            check("pc_plus4", pc_plus4, exp_addr + 32'd4);
            check("inst_valid", inst_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("inst_head", {inst_pc, inst_data}, exp_q[0]);
            else                   check("inst_empty", {inst_pc, inst_data}, 64'h0);
            hs = exp_vld && drv_req_ready;
            if (exp_q.size() != 0 && drv_inst_ready) void'(exp_q.pop_front());
            if (resp_now) begin
                if (!out_killed && !drv_redirect) exp_q.push_back({out_addr, out_addr ^ K});
                out_vld = 0;
            end else if (out_vld) begin
                out_cnt--;
            end
            if (hs) begin
                out_vld    = 1;
                out_addr   = ea;
                out_cnt    = (rand_delay ? int'($urandom_range(3, 1)) : resp_delay) - 1;
                out_killed = hold_killed;
                if (!hold_killed) exp_addr = ea + 32'd4;
                hold = 0; hold_killed = 0;
            end else if (exp_vld) begin
                hold = 1; hold_addr = ea;
            end
            if (drv_redirect) begin
                exp_q.delete();
                exp_addr = drv_redirect_pc & ~32'h3;
                if (out_vld) out_killed = 1;
                if (hold) hold_killed = 1;
            end
            since_rst++;
        end
        cyc++;
    endtask

    task automatic do_reset();
        drv_rst_n = 0; drv_redirect = 0;
        repeat (3) step();
        drv_rst_n = 1;
        step();
    endtask

    task automatic wait_hs(input logic [31:0] a, input string tag);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            if (hs_this && hs_addr === a) found = 1;
        end
        check(tag, found, 1);
    endtask

    // Runs until the next accepted request and the next popped entry (bounded).
    task automatic next_hs_and_pop(output bit got_hs, output logic [31:0] a_hs,
                                   output bit got_pop, output logic [31:0] a_pop);
        got_hs = 0; got_pop = 0; a_hs = '0; a_pop = '0;
        for (int i = 0; i < 60 && !(got_hs && got_pop); i++) begin
            step();
            if (hs_this && !got_hs)   begin got_hs = 1;  a_hs = hs_addr; end
            if (pop_this && !got_pop) begin got_pop = 1; a_pop = pop_pc; end
        end
    endtask

    logic [31:0] pc_log[4], dat_log[4], wpc_log[4];
    int          cyc_log[4];
    int          np, n_hs, n_pops;
    bit          g_hs, g_pop;
    logic [31:0] a_hs, a_pop;

    initial begin
        rst_n = 0; redirect_valid = 0; redirect_pc = '0; imem_req_ready = 0;
        imem_resp_valid = 0; imem_resp_data = '0; inst_ready = 0;
        drv_rst_n = 0; drv_req_ready = 1; drv_inst_ready = 1; drv_redirect = 0;
        drv_redirect_pc = '0; junk_en = 0; rand_delay = 0;

        // Reset: three cycles low, then the first two cycles after release.
        repeat (3) step();
        check("rst_fetch_pc", fetch_pc, 32'h0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_w_fetch_pc", w_fetch_pc, WRAP_PC);
        check("rst_w_pc_plus4", w_pc_plus4, 32'h0);
        drv_rst_n = 1;
        step();
        check("c1_req_valid", imem_req_valid, 0);
        check("c1_fetch_pc", fetch_pc, 32'h0);
        step();
        check("c2_req_valid", imem_req_valid, 1);
        check("c2_req_addr", imem_req_addr, 32'h0);
        check("c2_w_req_addr", w_imem_req_addr, WRAP_PC);

        // Streaming with single-cycle memory; the wrap instance crosses 0xFFFFFFFC -> 0x0.
        np = 0;
        for (int i = 0; i < 40 && np < 4; i++) begin
            step();
            if (pop_this) begin
                pc_log[np] = pop_pc; dat_log[np] = pop_dat; cyc_log[np] = cyc;
                wpc_log[np] = w_inst_pc; np++;
            end
        end
        check("stream_pops", np, 4);
        for (int i = 0; i < np; i++) begin
            check($sformatf("stream_pc%0d", i), pc_log[i], 32'(4 * i));
            check($sformatf("stream_dat%0d", i), dat_log[i], 32'(4 * i) ^ K);
            if (i > 0) check($sformatf("stream_gap%0d", i), cyc_log[i] - cyc_log[i-1], 2);
        end
        if (np >= 2) begin
            check("wrap_pc0", wpc_log[0], WRAP_PC);
            check("wrap_pc1", wpc_log[1], 32'h0);
        end

        // Backpressure: decode stalled, only two fetches may be outstanding/buffered.
        drv_inst_ready = 0;
        do_reset();
        n_hs = 0;
        repeat (12) begin step(); if (hs_this) n_hs++; end
        check("bp_hs_count", n_hs, 2);
        check("bp_req_idle", imem_req_valid, 0);
        drv_inst_ready = 1;
        np = 0; g_hs = 0; a_hs = '0;
        for (int i = 0; i < 30 && !(np == 2 && g_hs); i++) begin
            step();
            if (pop_this && np < 2) begin pc_log[np] = pop_pc; np++; end
            if (hs_this && !g_hs) begin g_hs = 1; a_hs = hs_addr; end
        end
        check("bp_drain_cnt", np, 2);
        check("bp_drain0", pc_log[0], 32'h0);
        check("bp_drain1", pc_log[1], 32'h4);
        check("bp_resume_addr", a_hs, 32'h8);

        // Redirect while the 0x8 read is outstanding.
        do_reset();
        resp_delay = 2;
        wait_hs(32'h8, "wait_hs_8");
        drv_redirect = 1; drv_redirect_pc = 32'h103;
        step();
        drv_redirect = 0;
        next_hs_and_pop(g_hs, a_hs, g_pop, a_pop);
        check("rdw_next_req", a_hs, 32'h100);
        check("rdw_first_pc", a_pop, 32'h100);

        // Redirect in the same cycle as the 0x4 response.
        do_reset();
        resp_delay = 1;
        wait_hs(32'h4, "wait_hs_4");
        drv_redirect = 1; drv_redirect_pc = 32'h200;
        step();
        drv_redirect = 0;
        step();
        check("rdc_flushed", inst_valid, 0);
        check("rdc_req_valid", imem_req_valid, 1);
        check("rdc_req_addr", imem_req_addr, 32'h200);
        next_hs_and_pop(g_hs, a_hs, g_pop, a_pop);
        check("rdc_first_pc", a_pop, 32'h200);

        // Reset while waiting for a response with a buffered entry.
        drv_inst_ready = 0; resp_delay = 2;
        do_reset();
        wait_hs(32'h4, "wait_hs_4b");
        step();
        drv_rst_n = 0;
        step();
        drv_rst_n = 1;
        step();
        check("mrst_inst_valid", inst_valid, 0);
        check("mrst_w_inst_valid", w_inst_valid, 0);
        check("mrst_w_inst_data", w_inst_data, 32'h0);
        check("mrst_fetch_pc", fetch_pc, 32'h0);
        check("mrst_w_fetch_pc", w_fetch_pc, WRAP_PC);
        step();
        check("mrst_w_req_valid", w_imem_req_valid, 1);
        check("mrst_w_req_addr", w_imem_req_addr, WRAP_PC);

        // Random traffic against the model.
        do_reset();
        junk_en = 1; rand_delay = 1; n_pops = 0;
        for (int i = 0; i < 1500; i++) begin
            drv_req_ready   = ($urandom_range(3) != 0);
            drv_inst_ready  = ($urandom_range(2) != 0);
            drv_redirect    = ($urandom_range(19) == 0);
            drv_redirect_pc = $urandom;
            step();
            if (pop_this) n_pops++;
        end
        check("rand_progress", n_pops > 50, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
